// File: rtl/axi_ram_pkg.sv
// Shared constants and FSM state types for the AXI RAM responder.
package axi_ram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

endpackage

// File: rtl/axi_ram_responder_if.sv
// AXI4 bus bundle between a master and the RAM responder (slave side).
interface axi_ram_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awready, wready, bid, bresp, bvalid,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/axi_ram_addr_gen.sv
// Next-beat word index for one AXI burst, used by both the read and write paths.
// WRAP bursts are honoured only when AXI_RAM_RESPONDER_WRAP_EN is defined.
module axi_ram_addr_gen
  import axi_ram_pkg::*;
#(
  parameter int IDX_W = 12
) (
  input  logic [IDX_W-1:0] idx,
  input  logic [1:0]       burst,
  input  logic [7:0]       len,
  output logic [IDX_W-1:0] next_idx
);

  logic [IDX_W-1:0] incr_idx;
  assign incr_idx = idx + IDX_W'(1);

`ifdef AXI_RAM_RESPONDER_WRAP_EN
  logic             wrap_ok;
  logic [IDX_W-1:0] wrap_mask;
  // Window of len+1 words aligned to its own size; other lengths fall back to INCR.
  assign wrap_ok   = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  assign wrap_mask = IDX_W'(len[3:0]);
`else
  logic len_unused;
  assign len_unused = ^len;
`endif

  always_comb begin
    next_idx = incr_idx;
    case (burst)
      BURST_FIXED: next_idx = idx;
      BURST_INCR:  next_idx = incr_idx;
`ifdef AXI_RAM_RESPONDER_WRAP_EN
      BURST_WRAP:  next_idx = wrap_ok ? ((idx & ~wrap_mask) | (incr_idx & wrap_mask)) : incr_idx;
`else
      BURST_WRAP:  next_idx = incr_idx;
`endif
      default:     next_idx = incr_idx;
    endcase
  end

endmodule

// File: rtl/axi_ram_responder.sv
// AXI4 slave backed by a MEM_WORDS x 32-bit RAM with independent read and write FSMs.
// Define AXI_RAM_RESPONDER_WRAP_EN to honour WRAP bursts; otherwise they behave as INCR.
module axi_ram_responder
  import axi_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int MEM_WORDS  = 4096
) (
  input logic                clk,
  input logic                resetn,
  axi_ram_responder_if.slave s_axi
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  wstate_t             wstate;
  logic [IDX_W-1:0]    widx, widx_next;
  logic [7:0]          wlen, wcnt;
  logic [1:0]          wburst;
  logic [ID_WIDTH-1:0] wid;
  logic                w_fire;

  rstate_t             rstate;
  logic [IDX_W-1:0]    ridx, ridx_next;
  logic [7:0]          rlen, rcnt;
  logic [1:0]          rburst;

  // Transfer size is fixed at 4 bytes and address bits outside the word index alias.
  logic unused_bits;
  assign unused_bits = ^{s_axi.awsize, s_axi.arsize, s_axi.awaddr, s_axi.araddr};

  assign w_fire = s_axi.wvalid && s_axi.wready;

  axi_ram_addr_gen #(.IDX_W(IDX_W)) u_waddr (
    .idx(widx), .burst(wburst), .len(wlen), .next_idx(widx_next)
  );

  axi_ram_addr_gen #(.IDX_W(IDX_W)) u_raddr (
    .idx(ridx), .burst(rburst), .len(rlen), .next_idx(ridx_next)
  );

  // Write path: AW accept, data beats, single B response.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wstate        <= W_IDLE;
      s_axi.awready <= 1'b0;
      s_axi.wready  <= 1'b0;
      s_axi.bvalid  <= 1'b0;
      s_axi.bid     <= '0;
      s_axi.bresp   <= RESP_OKAY;
    end else begin
      case (wstate)
        W_IDLE: begin
          s_axi.awready <= 1'b1;
          if (s_axi.awvalid && s_axi.awready) begin
            widx          <= s_axi.awaddr[IDX_W+1:2];
            wlen          <= s_axi.awlen;
            wburst        <= s_axi.awburst;
            wid           <= s_axi.awid;
            wcnt          <= 8'd0;
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b1;
            wstate        <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            widx <= widx_next;
            wcnt <= wcnt + 8'd1;
            // Either an early wlast or the (len+1)th beat closes the burst.
            if (s_axi.wlast || (wcnt == wlen)) begin
              s_axi.wready <= 1'b0;
              s_axi.bvalid <= 1'b1;
              s_axi.bid    <= wid;
              s_axi.bresp  <= RESP_OKAY;
              wstate       <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            s_axi.bvalid  <= 1'b0;
            s_axi.awready <= 1'b1;
            wstate        <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && w_fire) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (s_axi.wstrb[b]) mem[widx][8*b +: 8] <= s_axi.wdata[8*b +: 8];
      end
    end
  end

  // Read path: one fetch cycle per beat, so a same-cycle write to the word reads old data.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rstate        <= R_IDLE;
      s_axi.arready <= 1'b0;
      s_axi.rvalid  <= 1'b0;
      s_axi.rlast   <= 1'b0;
      s_axi.rid     <= '0;
      s_axi.rdata   <= '0;
      s_axi.rresp   <= RESP_OKAY;
    end else begin
      case (rstate)
        R_IDLE: begin
          s_axi.arready <= 1'b1;
          if (s_axi.arvalid && s_axi.arready) begin
            ridx          <= s_axi.araddr[IDX_W+1:2];
            rlen          <= s_axi.arlen;
            rburst        <= s_axi.arburst;
            rcnt          <= 8'd0;
            s_axi.rid     <= s_axi.arid;
            s_axi.arready <= 1'b0;
            rstate        <= R_FETCH;
          end
        end
        R_FETCH: begin
          s_axi.rdata  <= mem[ridx];
          s_axi.rvalid <= 1'b1;
          s_axi.rlast  <= (rcnt == rlen);
          s_axi.rresp  <= RESP_OKAY;
          rstate       <= R_DATA;
        end
        R_DATA: begin
          if (s_axi.rready) begin
            s_axi.rvalid <= 1'b0;
            s_axi.rlast  <= 1'b0;
            if (rcnt == rlen) begin
              s_axi.arready <= 1'b1;
              rstate        <= R_IDLE;
            end else begin
              rcnt   <= rcnt + 8'd1;
              ridx   <= ridx_next;
              rstate <= R_FETCH;
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ram_responder.sv
// Bench for axi_ram_responder: directed vector table, multi-cycle corner sequences and
// randomized bursts checked against a word-array reference model.
module tb_axi_ram_responder;
  import axi_ram_pkg::*;

  localparam int MEM = 4096;
  localparam int TMO = 50;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  axi_ram_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(1)) ifc ();

  axi_ram_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(1), .MEM_WORDS(MEM)
  ) dut (
    .clk(clk), .resetn(resetn), .s_axi(ifc)
  );

  int          vectors    = 0;
  int          miscompares = 0;
  logic [31:0] model [MEM];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic [31:0] er [256];
  bit          use_er;

  typedef struct {
    logic [31:0] rd_addr;
    logic [31:0] wr_addr;
    logic [31:0] pre;
    logic [3:0]  strb;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Word touched by beat 'beat' of a burst, from the addressing rules.
  function automatic int word_at(logic [31:0] addr, logic [1:0] burst, int len, int beat);
    int start, win, base;
    start = int'((addr >> 2) % 32'd4096);
    if (burst == 2'b00) return start;
`ifdef AXI_RAM_RESPONDER_WRAP_EN
    if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      win  = len + 1;
      base = (start / win) * win;
      return base + ((start - base + beat) % win);
    end
`endif
    return (start + beat) % MEM;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic id, input int len,
                           input logic [1:0] burst, input int last_at, input int b_delay);
    int n, nb, w;
    ifc.awaddr = addr; ifc.awid = id; ifc.awlen = 8'(len); ifc.awburst = burst;
    ifc.awsize = 3'($urandom); ifc.awvalid = 1'b1;
    n = 0;
    while (!ifc.awready && n < TMO) begin @(posedge clk); #1; n++; end
    check("awready_wait", ifc.awready, 1);
    @(posedge clk); #1;
    ifc.awvalid = 1'b0;
    nb = (last_at >= 0 && last_at < len) ? last_at + 1 : len + 1;
    for (int i = 0; i < nb; i++) begin
      ifc.wdata = wd[i]; ifc.wstrb = ws[i]; ifc.wlast = (i == last_at); ifc.wvalid = 1'b1;
      n = 0;
      while (!ifc.wready && n < TMO) begin @(posedge clk); #1; n++; end
      check("wready_wait", ifc.wready, 1);
      @(posedge clk); #1;
      w = word_at(addr, burst, len, i);
      for (int b = 0; b < 4; b++) if (ws[i][b]) model[w][8*b +: 8] = wd[i][8*b +: 8];
    end
    ifc.wvalid = 1'b0; ifc.wlast = 1'b0;
    n = 0;
    while (!ifc.bvalid && n < TMO) begin @(posedge clk); #1; n++; end
    check("bvalid_wait", ifc.bvalid, 1);
    for (int k = 0; k < b_delay; k++) begin
      @(posedge clk); #1;
      check("bvalid_hold", ifc.bvalid, 1);
      check("awready_in_resp", ifc.awready, 0);
    end
    check("bresp", ifc.bresp, RESP_OKAY);
    check("bid", ifc.bid, id);
    ifc.bready = 1'b1;
    @(posedge clk); #1;
    ifc.bready = 1'b0;
    check("bvalid_clear", ifc.bvalid, 0);
  endtask

  task automatic ar_send(input logic [31:0] addr, input logic id, input int len, input logic [1:0] burst);
    int n;
    ifc.araddr = addr; ifc.arid = id; ifc.arlen = 8'(len); ifc.arburst = burst;
    ifc.arsize = 3'($urandom); ifc.arvalid = 1'b1;
    n = 0;
    while (!ifc.arready && n < TMO) begin @(posedge clk); #1; n++; end
    check("arready_wait", ifc.arready, 1);
    @(posedge clk); #1;
    ifc.arvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic id, input int len,
                          input logic [1:0] burst, input int r_delay);
    int n;
    logic [31:0] d0, expv;
    ar_send(addr, id, len, burst);
    for (int i = 0; i <= len; i++) begin
      n = 0;
      while (!ifc.rvalid && n < TMO) begin @(posedge clk); #1; n++; end
      check("rvalid_wait", ifc.rvalid, 1);
      d0 = ifc.rdata;
      for (int k = 0; k < r_delay; k++) begin
        @(posedge clk); #1;
        check("rvalid_hold", ifc.rvalid, 1);
        check("rdata_stable", ifc.rdata, d0);
      end
      expv = use_er ? er[i] : model[word_at(addr, burst, len, i)];
      check("rdata", ifc.rdata, expv);
      check("rlast", ifc.rlast, (i == len));
      check("rid", ifc.rid, id);
      check("rresp", ifc.rresp, RESP_OKAY);
      ifc.rready = 1'b1;
      @(posedge clk); #1;
      ifc.rready = 1'b0;
    end
    check("arready_idle", ifc.arready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete, required completion");
    $fatal(1);
  end

  initial begin
    int n, len, last_at, r;
    logic [31:0] a;
    logic [1:0] bu;
    logic id;

    tbl[0] = '{32'h0000_0100, 32'h0000_0100, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tbl[1] = '{32'h0000_0300, 32'h0000_0300, 32'hFFFF_FFFF, 4'h2, 32'h0000_AB00, 32'hFFFF_ABFF};
    tbl[2] = '{32'h0000_0304, 32'h0000_0304, 32'h1234_5678, 4'h1, 32'hAAAA_AAAA, 32'h1234_56AA};
    tbl[3] = '{32'h0000_0308, 32'h0000_0308, 32'h1234_5678, 4'h8, 32'hBB00_0000, 32'hBB34_5678};
    tbl[4] = '{32'h0000_030C, 32'h0000_030C, 32'h1234_5678, 4'h0, 32'hFFFF_FFFF, 32'h1234_5678};
    tbl[5] = '{32'h0000_0310, 32'h0000_0310, 32'h0000_0000, 4'h5, 32'h1122_3344, 32'h0022_0044};
    tbl[6] = '{32'h0000_0314, 32'hC000_4314, 32'h5555_5555, 4'hF, 32'hCAFE_F00D, 32'hCAFE_F00D};
    tbl[7] = '{32'h0000_3FFC, 32'h0000_7FFC, 32'h0000_1111, 4'hC, 32'h9ABC_FFFF, 32'h9ABC_1111};

    resetn = 1'b0; use_er = 1'b0;
    ifc.awvalid = 0; ifc.awid = '0; ifc.awaddr = '0; ifc.awlen = '0; ifc.awsize = '0; ifc.awburst = '0;
    ifc.wvalid = 0; ifc.wdata = '0; ifc.wstrb = '0; ifc.wlast = 0; ifc.bready = 0;
    ifc.arvalid = 0; ifc.arid = '0; ifc.araddr = '0; ifc.arlen = '0; ifc.arsize = '0; ifc.arburst = '0;
    ifc.rready = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", ifc.awready, 0);
    check("rst_wready", ifc.wready, 0);
    check("rst_bvalid", ifc.bvalid, 0);
    check("rst_arready", ifc.arready, 0);
    check("rst_rvalid", ifc.rvalid, 0);
    check("rst_rdata", ifc.rdata, 0);
    check("rst_rlast", ifc.rlast, 0);
    check("rst_bid", ifc.bid, 0);
    resetn = 1'b1;
    @(posedge clk); #1;
    check("awready_after_rst", ifc.awready, 1);
    check("arready_after_rst", ifc.arready, 1);

    // Preload words 0..511 so every later read hits known contents.
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      axi_write(32'(p * 1024), 1'b0, 255, BURST_INCR, 255, 0);
    end

    // Vector table: prefill, strobed/aliased write, single-beat read back.
    for (int v = 0; v < 8; v++) begin
      wd[0] = tbl[v].pre; ws[0] = 4'hF;
      axi_write(tbl[v].rd_addr, 1'b0, 0, BURST_INCR, 0, 0);
      wd[0] = tbl[v].data; ws[0] = tbl[v].strb;
      axi_write(tbl[v].wr_addr, 1'b1, 0, BURST_INCR, 0, 0);
      er[0] = tbl[v].exp; use_er = 1'b1;
      axi_read(tbl[v].rd_addr, 1'b0, 0, BURST_INCR, 0);
      use_er = 1'b0;
    end

    // INCR burst of four
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; er[i] = 32'(i + 1); end
    axi_write(32'h200, 1'b0, 3, BURST_INCR, 3, 0);
    use_er = 1'b1;
    axi_read(32'h200, 1'b1, 3, BURST_INCR, 0);

    // FIXED burst keeps hitting one word
    wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF;
    axi_write(32'h50, 1'b0, 2, BURST_FIXED, 2, 0);
    er[0] = 32'hC; er[1] = 32'hC;
    axi_read(32'h50, 1'b0, 1, BURST_FIXED, 0);
    use_er = 1'b0;
    axi_read(32'h54, 1'b0, 1, BURST_INCR, 0);

    // Backpressure on B and R
    wd[0] = 32'h1357_9BDF; ws[0] = 4'hF;
    axi_write(32'h500, 1'b1, 0, BURST_INCR, 0, 5);
    axi_read(32'h500, 1'b1, 0, BURST_INCR, 5);

    // Early wlast ends the burst after two beats
    for (int i = 0; i < 4; i++) begin wd[i] = 32'h11 * (i + 1); ws[i] = 4'hF; end
    axi_write(32'h60, 1'b0, 3, BURST_INCR, 1, 0);
    axi_read(32'h60, 1'b0, 3, BURST_INCR, 1);

    // WRAP read of four at 0x38
    for (int i = 0; i < 6; i++) begin wd[i] = 32'(32'h30 + 4 * i); ws[i] = 4'hF; end
    axi_write(32'h30, 1'b0, 5, BURST_INCR, 5, 0);
`ifdef AXI_RAM_RESPONDER_WRAP_EN
    er[0] = 32'h38; er[1] = 32'h3C; er[2] = 32'h30; er[3] = 32'h34;
`else
    er[0] = 32'h38; er[1] = 32'h3C; er[2] = 32'h40; er[3] = 32'h44;
`endif
    use_er = 1'b1;
    axi_read(32'h38, 1'b0, 3, BURST_WRAP, 0);
    use_er = 1'b0;

    // Reset during beat 2 of an eight-beat read
    ar_send(32'h400, 1'b0, 7, BURST_INCR);
    for (int i = 0; i < 2; i++) begin
      n = 0;
      while (!ifc.rvalid && n < TMO) begin @(posedge clk); #1; n++; end
      check("mr_rvalid", ifc.rvalid, 1);
      check("mr_rdata", ifc.rdata, model[word_at(32'h400, BURST_INCR, 7, i)]);
      ifc.rready = 1'b1;
      @(posedge clk); #1;
      ifc.rready = 1'b0;
    end
    n = 0;
    while (!ifc.rvalid && n < TMO) begin @(posedge clk); #1; n++; end
    check("mr_beat2_valid", ifc.rvalid, 1);
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    check("mr_rvalid_drop", ifc.rvalid, 0);
    @(posedge clk); #1;
    check("mr_arready", ifc.arready, 1);
    axi_read(32'h400, 1'b0, 7, BURST_INCR, 0);

    // Randomized bursts against the model
    for (int t = 0; t < 40; t++) begin
      a  = ($urandom_range(0, 255) << 2) | ($urandom_range(0, 15) << 14);
      len = $urandom_range(0, 15);
      bu = 2'($urandom_range(0, 3));
      id = 1'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
        r = $urandom_range(0, 3);
        last_at = (r == 0) ? int'($urandom_range(0, len + 2)) : ((r == 1) ? -1 : len);
        axi_write(a, id, len, bu, last_at, $urandom_range(0, 2));
      end else begin
        axi_read(a, id, len, bu, $urandom_range(0, 2));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
